// File: rtl/state_checker.sv
// Compares core state snapshots taken at each FETCH against a preloaded table
// of expected snapshots and reports mismatches, error totals and the first failure.
module state_checker #(
  parameter int STATE_WIDTH   = 160,
  parameter int NUM_DUMPS     = 86,
  parameter int IDX_WIDTH     = 7,
  parameter int SKIP_FIRST    = 1,
  parameter int STOP_ON_ERROR = 0
) (
  input  logic                   clk_100mhz,
  input  logic                   rst_n,
  input  logic                   load_en,
  input  logic [IDX_WIDTH-1:0]   load_addr,
  input  logic [STATE_WIDTH-1:0] load_data,
  input  logic [STATE_WIDTH-1:0] compare_mask,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   sample_valid,
  input  logic [STATE_WIDTH-1:0] state_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   mismatch,
  output logic [IDX_WIDTH-1:0]   error_count,
  output logic                   first_err_valid,
  output logic [IDX_WIDTH-1:0]   first_err_index,
  output logic [STATE_WIDTH-1:0] first_err_state,
  output logic [IDX_WIDTH-1:0]   current_index,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_RUN, S_DONE} state_t;

  localparam int                   IW1       = IDX_WIDTH + 1;
  localparam logic [IDX_WIDTH:0]   DUMPS_W   = IW1'(NUM_DUMPS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_DUMPS - 1);
  localparam logic [1:0]           SKIP_LAST = 2'(SKIP_FIRST - 1);

  state_t                 state;
  logic [1:0]             skip_cnt;
  logic [STATE_WIDTH-1:0] exp_mem [NUM_DUMPS];
  logic [STATE_WIDTH-1:0] exp_word;
  logic                   hit;
  logic                   load_ok;

  // Handshake: sample_valid is a single-cycle strobe with no back-pressure;
  // every strobe seen in RUN consumes exactly one table entry, strobes in
  // IDLE or DONE are dropped, strobes in SKIP only advance the skip counter.
  assign exp_word  = exp_mem[current_index];
  assign hit       = |((state_in ^ exp_word) & compare_mask);
  assign load_ok   = load_en && ((state == S_IDLE) || (state == S_DONE)) &&
                     ({1'b0, load_addr} < DUMPS_W);
  assign fsm_state = state;

  // The table has no reset so its contents outlive rst_n and abort.
  always_ff @(posedge clk_100mhz) begin
    if (load_ok) exp_mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      skip_cnt        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mismatch        <= 1'b0;
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_index <= '0;
      first_err_state <= '0;
      current_index   <= '0;
    end else begin
      mismatch <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
        pass  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              error_count     <= '0;
              first_err_valid <= 1'b0;
              current_index   <= '0;
              skip_cnt        <= '0;
              done            <= 1'b0;
              pass            <= 1'b0;
              busy            <= 1'b1;
              state           <= (SKIP_FIRST > 0) ? S_SKIP : S_RUN;
            end
          end
          S_SKIP: begin
            if (sample_valid) begin
              skip_cnt <= skip_cnt + 2'd1;
              if (skip_cnt == SKIP_LAST) state <= S_RUN;
            end
          end
          S_RUN: begin
            if (sample_valid) begin
              current_index <= current_index + 1'b1;
              if (hit) begin
                mismatch <= 1'b1;
                if (error_count != '1) error_count <= error_count + 1'b1;
                if (!first_err_valid) begin
                  first_err_valid <= 1'b1;
                  first_err_index <= current_index;
                  first_err_state <= state_in;
                end
              end
              if ((current_index == LAST_IDX) || ((STOP_ON_ERROR != 0) && hit)) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (error_count == '0) && !hit;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_state_checker.sv
// Bench for state_checker: three instances (default, stop-on-error, 3-bit saturation)
// share stimulus; a scoreboard queue holds the expected mismatch bit per sample.
module tb_state_checker;
  localparam int SW = 160;

  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  logic          rst_n, abort, sample_valid;
  logic          load_en_m, load_en_s, load_en_q, start_m, start_s, start_q;
  logic [6:0]    load_addr;
  logic [SW-1:0] load_data, compare_mask, state_in;

  logic busy_m, done_m, pass_m, mismatch_m, fev_m;
  logic [6:0] ec_m, fei_m, ci_m;
  logic [SW-1:0] fes_m;
  logic [1:0] fsm_m;
  logic busy_s, done_s, pass_s, mismatch_s, fev_s;
  logic [6:0] ec_s, fei_s, ci_s;
  logic [SW-1:0] fes_s;
  logic [1:0] fsm_s;
  logic busy_q, done_q, pass_q, mismatch_q, fev_q;
  logic [2:0] ec_q, fei_q, ci_q;
  logic [SW-1:0] fes_q;
  logic [1:0] fsm_q;

  state_checker dut (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n), .load_en(load_en_m), .load_addr(load_addr),
    .load_data(load_data), .compare_mask(compare_mask), .start(start_m), .abort(abort),
    .sample_valid(sample_valid), .state_in(state_in), .busy(busy_m), .done(done_m),
    .pass(pass_m), .mismatch(mismatch_m), .error_count(ec_m), .first_err_valid(fev_m),
    .first_err_index(fei_m), .first_err_state(fes_m), .current_index(ci_m), .fsm_state(fsm_m));

  state_checker #(.STOP_ON_ERROR(1)) dut_stop (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n), .load_en(load_en_s), .load_addr(load_addr),
    .load_data(load_data), .compare_mask(compare_mask), .start(start_s), .abort(abort),
    .sample_valid(sample_valid), .state_in(state_in), .busy(busy_s), .done(done_s),
    .pass(pass_s), .mismatch(mismatch_s), .error_count(ec_s), .first_err_valid(fev_s),
    .first_err_index(fei_s), .first_err_state(fes_s), .current_index(ci_s), .fsm_state(fsm_s));

  state_checker #(.IDX_WIDTH(3), .NUM_DUMPS(8)) dut_sat (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n), .load_en(load_en_q), .load_addr(load_addr[2:0]),
    .load_data(load_data), .compare_mask(compare_mask), .start(start_q), .abort(abort),
    .sample_valid(sample_valid), .state_in(state_in), .busy(busy_q), .done(done_q),
    .pass(pass_q), .mismatch(mismatch_q), .error_count(ec_q), .first_err_valid(fev_q),
    .first_err_index(fei_q), .first_err_state(fes_q), .current_index(ci_q), .fsm_state(fsm_q));

  logic [0:0]    exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          track = 1'b0;
  int            sel = 0;
  logic [SW-1:0] exp_tab [86];
  logic [SW-1:0] pc_flip;
  logic [SW-1:0] err_state;

  // Scoreboard monitor: pops one expected bit per sample, expects quiet otherwise.
  logic       mon_sv, mon_mis;
  logic [0:0] mon_exp;
  always @(posedge clk_100mhz) begin
    mon_sv = sample_valid;
    #1;
    if (track) begin
      mon_mis = (sel == 0) ? mismatch_m : (sel == 1) ? mismatch_s : mismatch_q;
      mon_exp = 1'b0;
      if (mon_sv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_underflow got empty queue exp one entry at %0t", $time);
        end else mon_exp = exp_q.pop_front();
      end
      checks++;
      if (mon_mis !== mon_exp[0]) begin
        errors++;
        $display("FAIL mismatch_pulse sel=%0d t=%0t got %b exp %b", sel, $time, mon_mis, mon_exp);
      end
    end
  end

  function automatic logic [SW-1:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic pulse_start(input int which);
    @(negedge clk_100mhz);
    start_m = (which == 0); start_s = (which == 1); start_q = (which == 2);
    @(negedge clk_100mhz);
    start_m = 1'b0; start_s = 1'b0; start_q = 1'b0;
  endtask

  task automatic load_entry(input int which, input logic [6:0] addr, input logic [SW-1:0] data);
    @(negedge clk_100mhz);
    load_en_m = (which == 0); load_en_s = (which == 1); load_en_q = (which == 2);
    load_addr = addr; load_data = data;
    @(negedge clk_100mhz);
    load_en_m = 1'b0; load_en_s = 1'b0; load_en_q = 1'b0;
  endtask

  task automatic drive_sample(input logic [SW-1:0] s, input logic e);
    @(negedge clk_100mhz);
    sample_valid = 1'b1; state_in = s;
    exp_q.push_back(e);
  endtask

  task automatic end_samples();
    @(negedge clk_100mhz);
    sample_valid = 1'b0;
    @(negedge clk_100mhz);
  endtask

  // One skipped sample then n compared samples; err_idx gets flip applied.
  task automatic run_samples(input int n, input int err_idx, input logic [SW-1:0] flip,
                             input logic ignore_after_err);
    logic [SW-1:0] s;
    logic          stopped;
    stopped = 1'b0;
    drive_sample(rand_state(), 1'b0);
    for (int i = 0; i < n; i++) begin
      s = exp_tab[i] ^ ((i == err_idx) ? flip : '0);
      if (i == err_idx) err_state = s;
      drive_sample(s, !stopped && (|((s ^ exp_tab[i]) & compare_mask)));
      if (ignore_after_err && (i == err_idx)) stopped = 1'b1;
    end
    end_samples();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; sample_valid = 1'b0; state_in = '0;
    load_en_m = 1'b0; load_en_s = 1'b0; load_en_q = 1'b0; load_addr = '0; load_data = '0;
    start_m = 1'b0; start_s = 1'b0; start_q = 1'b0; compare_mask = '1;
    repeat (3) @(negedge clk_100mhz);
    checks++; if ({busy_m, done_m, pass_m, mismatch_m, fev_m} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy_m, done_m, pass_m, mismatch_m, fev_m}); end
    checks++; if ({ec_m, fei_m, ci_m} !== 21'd0) begin errors++; $display("FAIL reset_counters got %h exp 0", {ec_m, fei_m, ci_m}); end
    checks++; if (fes_m !== '0) begin errors++; $display("FAIL reset_first_state got %h exp 0", fes_m); end
    rst_n = 1'b1;
    @(negedge clk_100mhz);
  endtask

  task automatic test_all_match();
    for (int i = 0; i < 86; i++) begin
      exp_tab[i] = rand_state();
      load_entry(0, 7'(i), exp_tab[i]);
    end
    sel = 0; track = 1'b1;
    pulse_start(0);
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b exp 1", busy_m); end
    run_samples(86, -1, '0, 1'b0);
    checks++; if ({done_m, pass_m, busy_m} !== 3'b110) begin errors++; $display("FAIL match_done_pass got %b exp 110", {done_m, pass_m, busy_m}); end
    checks++; if (ec_m !== 7'd0) begin errors++; $display("FAIL match_err_count got %0d exp 0", ec_m); end
    checks++; if (ci_m !== 7'd86) begin errors++; $display("FAIL match_index got %0d exp 86", ci_m); end
  endtask

  task automatic test_pc_error();
    pulse_start(0);
    run_samples(86, 5, pc_flip, 1'b0);
    checks++; if (ec_m !== 7'd1) begin errors++; $display("FAIL pc_err_count got %0d exp 1", ec_m); end
    checks++; if ({fev_m, fei_m} !== {1'b1, 7'd5}) begin errors++; $display("FAIL pc_first_index got %b/%0d exp 1/5", fev_m, fei_m); end
    checks++; if (fes_m !== err_state) begin errors++; $display("FAIL pc_first_state got %h exp %h", fes_m, err_state); end
    checks++; if ({done_m, pass_m} !== 2'b10) begin errors++; $display("FAIL pc_pass got %b exp 10", {done_m, pass_m}); end
  endtask

  task automatic test_masked();
    compare_mask = {{(SW-16){1'b1}}, 16'h0000};
    pulse_start(0);
    run_samples(86, 5, pc_flip, 1'b0);
    checks++; if ({done_m, pass_m, fev_m} !== 3'b110) begin errors++; $display("FAIL masked_pass got %b exp 110", {done_m, pass_m, fev_m}); end
    checks++; if (ec_m !== 7'd0) begin errors++; $display("FAIL masked_err_count got %0d exp 0", ec_m); end
    compare_mask = '1;
  endtask

  task automatic test_stop_on_error();
    logic [SW-1:0] s;
    for (int i = 0; i < 86; i++) load_entry(1, 7'(i), exp_tab[i]);
    sel = 1;
    pulse_start(1);
    drive_sample(rand_state(), 1'b0);
    for (int i = 0; i < 10; i++) begin
      s = exp_tab[i] ^ (((i == 3) || (i == 7)) ? pc_flip : '0);
      drive_sample(s, i == 3);
    end
    end_samples();
    checks++; if ({done_s, pass_s} !== 2'b10) begin errors++; $display("FAIL stop_done got %b exp 10", {done_s, pass_s}); end
    checks++; if (ec_s !== 7'd1) begin errors++; $display("FAIL stop_err_count got %0d exp 1", ec_s); end
    checks++; if (ci_s !== 7'd4) begin errors++; $display("FAIL stop_index got %0d exp 4", ci_s); end
    checks++; if (fei_s !== 7'd3) begin errors++; $display("FAIL stop_first_index got %0d exp 3", fei_s); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) load_entry(2, 7'(i), exp_tab[i]);
    sel = 2;
    pulse_start(2);
    drive_sample(rand_state(), 1'b0);
    for (int i = 0; i < 8; i++) drive_sample(exp_tab[i] ^ 160'd1, 1'b1);
    end_samples();
    checks++; if (ec_q !== 3'd7) begin errors++; $display("FAIL sat_err_count got %0d exp 7", ec_q); end
    checks++; if ({done_q, pass_q, ci_q} !== {2'b10, 3'd0}) begin errors++; $display("FAIL sat_done got %b exp 10000", {done_q, pass_q, ci_q}); end
  endtask

  task automatic test_busy_guards();
    sel = 0;
    pulse_start(0);
    run_samples(3, -1, '0, 1'b0);
    @(negedge clk_100mhz);
    start_m = 1'b1; load_en_m = 1'b1; load_addr = 7'd0; load_data = ~exp_tab[0];
    @(negedge clk_100mhz);
    start_m = 1'b0; load_en_m = 1'b0;
    checks++; if ({busy_m, ci_m} !== {1'b1, 7'd3}) begin errors++; $display("FAIL start_while_busy got %b/%0d exp 1/3", busy_m, ci_m); end
    abort = 1'b1; start_m = 1'b1;
    @(negedge clk_100mhz);
    abort = 1'b0; start_m = 1'b0;
    checks++; if ({busy_m, done_m, fsm_m} !== 4'b0000) begin errors++; $display("FAIL abort_idle got %b exp 0000", {busy_m, done_m, fsm_m}); end
    checks++; if (ci_m !== 7'd3) begin errors++; $display("FAIL abort_keeps_index got %0d exp 3", ci_m); end
    pulse_start(0);
    run_samples(86, -1, '0, 1'b0);
    checks++; if ({done_m, pass_m, ec_m} !== {2'b11, 7'd0}) begin errors++; $display("FAIL busy_load_ignored got %b exp 110000000", {done_m, pass_m, ec_m}); end
  endtask

  task automatic test_load_with_start();
    @(negedge clk_100mhz);
    exp_tab[0] = rand_state();
    load_en_m = 1'b1; load_addr = 7'd0; load_data = exp_tab[0]; start_m = 1'b1;
    @(negedge clk_100mhz);
    load_en_m = 1'b0; start_m = 1'b0;
    run_samples(2, -1, '0, 1'b0);
    checks++; if ({busy_m, ci_m, ec_m} !== {1'b1, 7'd2, 7'd0}) begin errors++; $display("FAIL load_start got %b exp 1 2 0", {busy_m, ci_m, ec_m}); end
    @(negedge clk_100mhz) abort = 1'b1;
    @(negedge clk_100mhz) abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    pulse_start(0);
    run_samples(40, 10, pc_flip, 1'b0);
    checks++; if ({busy_m, ci_m, ec_m} !== {1'b1, 7'd40, 7'd1}) begin errors++; $display("FAIL pre_reset got %b exp 1 40 1", {busy_m, ci_m, ec_m}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy_m, done_m, pass_m, mismatch_m, fev_m, ec_m, fei_m, ci_m} !== 26'd0) begin errors++; $display("FAIL mid_reset_outputs got %h exp 0", {busy_m, done_m, pass_m, mismatch_m, fev_m, ec_m, fei_m, ci_m}); end
    checks++; if (fes_m !== '0) begin errors++; $display("FAIL mid_reset_first_state got %h exp 0", fes_m); end
    @(negedge clk_100mhz) rst_n = 1'b1;
    pulse_start(0);
    run_samples(86, 0, pc_flip, 1'b0);
    checks++; if ({ec_m, fei_m, done_m, pass_m} !== {7'd1, 7'd0, 2'b10}) begin errors++; $display("FAIL rerun got %b exp 0000001000000010", {ec_m, fei_m, done_m, pass_m}); end
    checks++; if (fes_m !== err_state) begin errors++; $display("FAIL rerun_first_state got %h exp %h", fes_m, err_state); end
  endtask

  initial begin
    pc_flip = {144'd0, 16'hbeef};
    test_reset();
    test_all_match();
    test_pc_error();
    test_masked();
    test_stop_on_error();
    test_saturate();
    test_busy_guards();
    test_load_with_start();
    test_reset_mid_run();
    track = 1'b0;
    @(negedge clk_100mhz);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
